// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg: shared types, sizes and helpers
// for the round-robin demux scheduler.
package demux_sched_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // One-hot decode of a channel select.
  function automatic logic [N_CH-1:0] onehot(
    input logic [SEL_W-1:0] sel
  );
    logic [N_CH-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin pick of
// the first requester at or after ptr (mod 4).
module rr_pick4
  import demux_sched_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] sel,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Scan ptr, ptr+1, ... ; the 2-bit add wraps mod 4.
  always_comb begin
    sel = ptr;
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = ptr + SEL_W'(k);
      if (!any && req[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_rr_sched.sv
// demux_rr_sched: round-robin owner of a 1-to-4 demux select.
// Optional macro DEMUX_SCHED_LOCK_EN adds a lock input that extends slots.
module demux_rr_sched
  import demux_sched_pkg::*;
#(
  parameter  int DWELL = 8,
  localparam int CNT_W = $clog2(DWELL + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_CH-1:0]  req,
`ifdef DEMUX_SCHED_LOCK_EN
  input  logic             lock,
`endif
  output logic [SEL_W-1:0] mode,
  output logic [N_CH-1:0]  grant,
  output logic             active,
  output logic             slot_done
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

  state_e           state_q;
  logic [SEL_W-1:0] mode_q;
  logic [N_CH-1:0]  grant_q;
  logic             active_q;
  logic             done_q;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [SEL_W-1:0] pick_sel;
  logic             pick_any;
  logic             req_own;
  logic             hold;
  logic             expire;
  logic             slot_end;
  logic             start;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .sel (pick_sel),
    .any (pick_any)
  );

  assign req_own = req[mode_q];

`ifdef DEMUX_SCHED_LOCK_EN
  // Lock only stretches a slot whose owner still requests.
  assign hold = lock & req_own;
`else
  assign hold = 1'b0;
`endif

  // All end causes fold into one term, so coincident causes
  // still yield a single slot_done pulse.
  assign expire   = (cnt_q == '0) & ~hold;
  assign slot_end = expire | ~req_own | ~en;
  assign start    = en & pick_any;

  // Counter saturates at zero while a lock holds the slot open.
  assign cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

  // Next priority starts just past the channel that was served.
  assign ptr_d = mode_q + 1'b1;

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      grant_q  <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, GAP: begin
          // mode moves only here, while grant is zero.
          if (start) begin
            mode_q   <= pick_sel;
            grant_q  <= onehot(pick_sel);
            active_q <= 1'b1;
            cnt_q    <= CNT_LOAD;
            state_q  <= GRANT;
          end else begin
            state_q  <= IDLE;
          end
        end
        GRANT: begin
          if (slot_end) begin
            grant_q  <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b1;
            ptr_q    <= ptr_d;
            state_q  <= GAP;
          end else begin
            cnt_q    <= cnt_d;
          end
        end
        default: begin
          grant_q  <= '0;
          active_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign mode      = mode_q;
  assign grant     = grant_q;
  assign active    = active_q;
  assign slot_done = done_q;

endmodule

// File: tb/tb_demux_rr_sched.sv
// tb_demux_rr_sched: vector table plus scoreboard for the
// round-robin demux scheduler (DWELL=4 main, DWELL=1 side).
module tb_demux_rr_sched;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       lock;
  logic [1:0] mode;
  logic [3:0] grant;
  logic       active;
  logic       slot_done;

  logic       rst1_n;
  logic       en1;
  logic [3:0] req1;
  logic       lock1;
  logic [1:0] mode1;
  logic [3:0] grant1;
  logic       active1;
  logic       done1;

  int total;
  int bad;

  typedef struct {
    logic       rn;
    logic       en;
    logic [3:0] rq;
    logic       lk;
    logic [3:0] g;
    logic [1:0] m;
    logic       sd;
  } vec_t;

  typedef struct {
    logic [3:0] g;
    logic [1:0] m;
    logic       sd;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  demux_rr_sched #(.DWELL(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
`ifdef DEMUX_SCHED_LOCK_EN
    .lock      (lock),
`endif
    .mode      (mode),
    .grant     (grant),
    .active    (active),
    .slot_done (slot_done)
  );

  demux_rr_sched #(.DWELL(1)) u_d1 (
    .clk       (clk),
    .rst_n     (rst1_n),
    .en        (en1),
    .req       (req1),
`ifdef DEMUX_SCHED_LOCK_EN
    .lock      (lock1),
`endif
    .mode      (mode1),
    .grant     (grant1),
    .active    (active1),
    .slot_done (done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void add(input int n, input logic rn,
      input logic e, input logic [3:0] rq, input logic lk,
      input logic [3:0] g, input logic [1:0] m, input logic sd);
    vec_t v;
    v.rn = rn; v.en = e; v.rq = rq; v.lk = lk;
    v.g = g; v.m = m; v.sd = sd;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    rst_n = v.rn; en = v.en; req = v.rq; lock = v.lk;
    e.g = v.g; e.m = v.m; e.sd = v.sd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d grant", idx), grant, e.g);
    chk($sformatf("v%0d mode", idx), {2'b00, mode}, {2'b00, e.m});
    chk($sformatf("v%0d done", idx), {3'b000, slot_done}, {3'b000, e.sd});
    chk($sformatf("v%0d active", idx), {3'b000, active},
        {3'b000, |e.g});
  endtask

  initial begin
    exp_t e;
    logic [3:0] pat[$];
    logic [1:0] mpat[$];
    int waited;
    total = 0; bad = 0;
    rst_n = 1'b0; en = 1'b1; req = 4'hF; lock = 1'b0;
    rst1_n = 1'b0; en1 = 1'b0; req1 = 4'h0; lock1 = 1'b0;

    // reset then full rotation with all channels requesting
    add(2, 0, 1, 4'hF, 0, 4'h0, 0, 0);
    add(4, 1, 1, 4'hF, 0, 4'h1, 0, 0);
    add(1, 1, 1, 4'hF, 0, 4'h0, 0, 1);
    add(4, 1, 1, 4'hF, 0, 4'h2, 1, 0);
    add(1, 1, 1, 4'hF, 0, 4'h0, 1, 1);
    add(4, 1, 1, 4'hF, 0, 4'h4, 2, 0);
    add(1, 1, 1, 4'hF, 0, 4'h0, 2, 1);
    add(4, 1, 1, 4'hF, 0, 4'h8, 3, 0);
    add(1, 1, 1, 4'hF, 0, 4'h0, 3, 1);
    add(1, 1, 1, 4'hF, 0, 4'h1, 0, 0);
    // reset mid-slot, then single persistent requester
    add(1, 0, 1, 4'h4, 0, 4'h0, 0, 0);
    add(4, 1, 1, 4'h4, 0, 4'h4, 2, 0);
    add(1, 1, 1, 4'h4, 0, 4'h0, 2, 1);
    add(1, 1, 1, 4'h4, 0, 4'h4, 2, 0);
    // early release of channel 1, others change meanwhile
    add(1, 0, 1, 4'h2, 0, 4'h0, 0, 0);
    add(1, 1, 1, 4'h2, 0, 4'h2, 1, 0);
    add(1, 1, 1, 4'h7, 0, 4'h2, 1, 0);
    add(1, 1, 1, 4'h9, 0, 4'h0, 1, 1);
    add(1, 1, 1, 4'h9, 0, 4'h8, 3, 0);
    // enable dropped mid-slot
    add(1, 1, 0, 4'h9, 0, 4'h0, 3, 1);
    add(2, 1, 0, 4'h9, 0, 4'h0, 3, 0);
    add(1, 1, 1, 4'h9, 0, 4'h1, 0, 0);
    add(1, 0, 1, 4'h9, 0, 4'h0, 0, 0);
    // expiry + release + en low together: one pulse
    add(4, 1, 1, 4'h1, 0, 4'h1, 0, 0);
    add(1, 1, 0, 4'h0, 0, 4'h0, 0, 1);
    add(1, 1, 0, 4'h0, 0, 4'h0, 0, 0);
`ifdef DEMUX_SCHED_LOCK_EN
    // lock holds the slot past expiry
    add(1, 0, 1, 4'h8, 1, 4'h0, 0, 0);
    add(6, 1, 1, 4'h8, 1, 4'h8, 3, 0);
    add(1, 1, 1, 4'h8, 0, 4'h0, 3, 1);
    add(1, 1, 1, 4'h0, 0, 4'h0, 3, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // DWELL=1: grant, gap, grant, gap with continuous requests
    pat  = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    mpat = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    @(negedge clk);
    rst1_n = 1'b1; en1 = 1'b1; req1 = 4'hF;
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (!active1 && waited < 5);
    if (!active1) begin
      total++; bad++;
      $display("FAIL d1 first grant: got %h want active", grant1);
    end else begin
      for (int i = 0; i < pat.size(); i++) begin
        e.g = pat[i]; e.m = mpat[i]; e.sd = (i % 2 == 1);
        sb.push_back(e);
      end
      for (int i = 0; i < pat.size(); i++) begin
        if (i > 0) begin
          @(posedge clk);
          #1;
        end
        e = sb.pop_front();
        chk($sformatf("d1 grant%0d", i), grant1, e.g);
        chk($sformatf("d1 mode%0d", i), {2'b00, mode1}, {2'b00, e.m});
        chk($sformatf("d1 done%0d", i), {3'b000, done1},
            {3'b000, e.sd});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
